// File: rtl/rdcs_pkg.sv
// rdcs_pkg -- shared types and constants for the pipelined Kogge-Stone
// subtractor rdcs_sub32.
//
// Contents:
//   WIDTH, LEVELS   operand width and number of prefix levels (log2 WIDTH)
//   kpg_t           2-bit kill/propagate/generate code (KILL, PROP, GEN)
//   stage_t         one pipeline stage: valid, carry-in, a^~b, KPG vector
//                   (plus operand sign bits when RDCS_SUB32_FLAGS_EN is set)
//   kpg_init()      per-bit KPG code from a bit of a and a bit of ~b
//   kpg_combine()   prefix operator on a (high, low) pair of KPG codes
//
// Configuration macro: RDCS_SUB32_FLAGS_EN adds the sign bits to stage_t.
package rdcs_pkg;

  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KILL = 2'b00;
  localparam kpg_t PROP = 2'b01;
  localparam kpg_t GEN  = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic                   cin;    // ~bin, needed again to form diff[0]
    logic [WIDTH-1:0]       x;      // a ^ ~b, the half-sum
    kpg_t [WIDTH-1:0]       kpg;    // group KPG ending at each bit
`ifdef RDCS_SUB32_FLAGS_EN
    logic                   sign_a;
    logic                   sign_b;
`endif
  } stage_t;

  function automatic kpg_t kpg_init(input logic a_bit, input logic bn_bit);
    kpg_t code;
    if (a_bit & bn_bit)      code = GEN;
    else if (a_bit ^ bn_bit) code = PROP;
    else                     code = KILL;
    return code;
  endfunction

  // The high group decides unless it only propagates, in which case the
  // low group's outcome passes through.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == PROP) ? lo : hi;
  endfunction

endpackage

// File: rtl/rdcs_prefix_cell.sv
// rdcs_prefix_cell -- combinational Kogge-Stone prefix node.
//
// Ports:
//   hi_i   KPG code of the more significant group
//   lo_i   KPG code of the adjacent less significant group
//   out_o  KPG code of the merged group
module rdcs_prefix_cell
  import rdcs_pkg::*;
(
  input  logic [1:0] hi_i,
  input  logic [1:0] lo_i,
  output logic [1:0] out_o
);

  assign out_o = kpg_combine(hi_i, lo_i);

endmodule

// File: rtl/rdcs_sub32.sv
// rdcs_sub32 -- 32-bit subtractor, diff = a - b - bin, built as
// a + ~b + ~bin over a radix-2 Kogge-Stone prefix tree. One operand
// register stage plus one register stage per prefix level; diff/bout are
// formed combinationally from the last stage (latency 6, throughput 1).
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset, has priority over hold
//   hold       stall: every pipeline register keeps its value
//   in_valid   a/b/bin valid this cycle
//   a, b       minuend, subtrahend
//   bin        borrow-in
//   out_valid  diff/bout valid
//   diff       a - b - bin mod 2^32 (0 when out_valid is low)
//   bout       borrow-out, 1 when a < b + bin unsigned
//   zero, neg, ovf  result flags, only with RDCS_SUB32_FLAGS_EN defined
//
// Configuration macro: RDCS_SUB32_FLAGS_EN.
module rdcs_sub32 #(
  parameter int WIDTH  = rdcs_pkg::WIDTH,
  parameter int LEVELS = rdcs_pkg::LEVELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef RDCS_SUB32_FLAGS_EN
 ,output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  import rdcs_pkg::*;

  stage_t           stage_q [LEVELS+1];
  stage_t           stage_d [LEVELS+1];
  kpg_t [WIDTH-1:0] lvl_kpg [LEVELS];
  logic [WIDTH-1:0] b_n;
  stage_t           last;
  logic [WIDTH-1:0] carry_in;

  assign b_n = ~b;

  // Prefix level l merges each bit with the group 2^l positions below it;
  // bits below the span already hold their final prefix and pass through.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_cell
        rdcs_prefix_cell u_cell (
          .hi_i  (stage_q[l].kpg[i]),
          .lo_i  (stage_q[l].kpg[i-(1<<l)]),
          .out_o (lvl_kpg[l][i])
        );
      end else begin : g_pass
        assign lvl_kpg[l][i] = stage_q[l].kpg[i];
      end
    end
  end

  // NOTE: every signal written here gets a full default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    stage_d[0]       = '0;
    stage_d[0].valid = in_valid;
    stage_d[0].cin   = ~bin;
    stage_d[0].x     = a ^ b_n;
    for (int i = 0; i < WIDTH; i++) begin
      stage_d[0].kpg[i] = kpg_init(a[i], b_n[i]);
    end
    // Folding the carry-in into bit 0 resolves every prefix to KILL or GEN.
    if (stage_d[0].kpg[0] == PROP) begin
      stage_d[0].kpg[0] = stage_d[0].cin ? GEN : KILL;
    end
`ifdef RDCS_SUB32_FLAGS_EN
    stage_d[0].sign_a = a[WIDTH-1];
    stage_d[0].sign_b = b[WIDTH-1];
`endif
    for (int l = 0; l < LEVELS; l++) begin
      stage_d[l+1]     = stage_q[l];
      stage_d[l+1].kpg = lvl_kpg[l];
    end
  end

  // NOTE: pipeline state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value. All stages, data included,
  // are cleared on reset so a bubble or frozen output is deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l <= LEVELS; l++) stage_q[l] <= '0;
    end else if (!hold) begin
      for (int l = 0; l <= LEVELS; l++) stage_q[l] <= stage_d[l];
    end
  end

  assign last = stage_q[LEVELS];

  // Carry into bit i is the carry out of the prefix group [i-1:0].
  always_comb begin
    carry_in    = '0;
    carry_in[0] = last.cin;
    for (int i = 1; i < WIDTH; i++) begin
      carry_in[i] = (last.kpg[i-1] == GEN);
    end
  end

  assign out_valid = last.valid;
  assign diff      = last.valid ? (last.x ^ carry_in) : '0;
  assign bout      = last.valid & (last.kpg[WIDTH-1] != GEN);

`ifdef RDCS_SUB32_FLAGS_EN
  assign zero = last.valid & (diff == '0);
  assign neg  = last.valid & diff[WIDTH-1];
  // Signed overflow: operands of opposite sign and the result's sign
  // differs from the minuend's.
  assign ovf  = last.valid & (last.sign_a ^ last.sign_b)
                           & (diff[WIDTH-1] ^ last.sign_a);
`endif

endmodule

// File: tb/tb_rdcs_sub32.sv
// tb_rdcs_sub32 -- self-checking bench for rdcs_sub32. A reference model
// computes each result with plain 33-bit arithmetic and queues it with the
// count of non-stalled edges at which it was issued; it is due exactly six
// non-stalled edges later. Flag checks are active when RDCS_SUB32_FLAGS_EN
// is defined.
module tb_rdcs_sub32;

  typedef logic [36:0] bund_t;  // {out_valid, bout, diff, zero, neg, ovf}

  typedef struct {
    int unsigned idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
  } op_t;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic [31:0] diff;
  logic        bout;
  logic        fz, fn, fo;
  bund_t       obs;

  int          tests;
  int          failed;
  op_t         pend[$];
  int unsigned adv_cnt;
  logic        last_rst;
  logic        last_hold;
  bund_t       exp_last;
  bund_t       msk_last;

  rdcs_sub32 dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .diff      (diff),
    .bout      (bout)
`ifdef RDCS_SUB32_FLAGS_EN
   ,.zero      (fz),
    .neg       (fn),
    .ovf       (fo)
`endif
  );

`ifndef RDCS_SUB32_FLAGS_EN
  assign fz = 1'b0;
  assign fn = 1'b0;
  assign fo = 1'b0;
`endif

  assign obs = {out_valid, bout, diff, fz, fn, fo};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result: unsigned difference computed one bit wider.
  function automatic bund_t ref_result(input logic [31:0] ra, input logic [31:0] rb,
                                       input logic rbin);
    logic [32:0] full;
    logic        z, n, o;
    full = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
    z = 1'b0; n = 1'b0; o = 1'b0;
`ifdef RDCS_SUB32_FLAGS_EN
    z = (full[31:0] == 32'd0);
    n = full[31];
    o = (ra[31] != rb[31]) && (full[31] != ra[31]);
`endif
    return {1'b1, full[32], full[31:0], z, n, o};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Drive one cycle (inputs set before the rising edge), update the model,
  // and return at the following falling edge where outputs are sampled.
  task automatic clk_cycle(input logic h, input logic v, input logic [31:0] ai,
                           input logic [31:0] bi, input logic bini);
    op_t op;
    hold = h; in_valid = v; a = ai; b = bi; bin = bini;
    @(posedge clk);
    last_rst  = rst;
    last_hold = h & ~rst;
    if (rst) begin
      pend.delete();
    end else if (!h) begin
      if (v) begin
        op.idx = adv_cnt; op.a = ai; op.b = bi; op.bin = bini;
        pend.push_back(op);
      end
      adv_cnt++;
    end
    @(negedge clk);
  endtask

  // Expected output bundle and compare mask for the cycle just completed.
  // diff/bout are don't-care while out_valid is expected low.
  task automatic model_expect(output bund_t e, output bund_t m);
    op_t op;
    if (last_rst) begin
      e = '0; m = '1;
    end else if (last_hold) begin
      e = exp_last; m = msk_last;
    end else if (pend.size() > 0 && pend[0].idx + 6 == adv_cnt) begin
      op = pend.pop_front();
      e = ref_result(op.a, op.b, op.bin); m = '1;
    end else begin
      e = '0; m = {1'b1, 1'b0, 32'h0, 3'b111};
    end
    exp_last = e; msk_last = m;
  endtask

  task automatic test_reset();
    bund_t e, m;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk_cycle(1'b0, 1'b1, $urandom(), $urandom(), 1'($urandom()));
      model_expect(e, m);
      tests++;
      if ((obs & m) !== (e & m)) begin
        failed++;
        $display("FAIL reset c=%0d: got %h required %h", c, obs, e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    bund_t e, m;
    logic [31:0] va [5] = '{32'd10, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vb [5] = '{32'd3,  32'd1, 32'd1,         32'hFFFF_FFFF, 32'd0};
    logic        vc [5] = '{1'b0,   1'b0,  1'b0,          1'b1,          1'b1};
    for (int c = 0; c < 13; c++) begin
      if (c < 5) clk_cycle(1'b0, 1'b1, va[c], vb[c], vc[c]);
      else       clk_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      model_expect(e, m);
      tests++;
      if ((obs & m) !== (e & m)) begin
        failed++;
        $display("FAIL directed c=%0d: got v=%b bo=%b d=%h f=%b required v=%b bo=%b d=%h f=%b",
                 c, obs[36], obs[35], obs[34:3], obs[2:0], e[36], e[35], e[34:3], e[2:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bund_t e, m;
    int n_valid, first_c, last_c;
    n_valid = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) clk_cycle(1'b0, 1'b1, 32'(c * 1000), 32'(c), 1'(c & 1));
      else       clk_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      model_expect(e, m);
      tests++;
      if ((obs & m) !== (e & m)) begin
        failed++;
        $display("FAIL back_to_back c=%0d: got %h required %h", c, obs, e);
      end
      if (out_valid === 1'b1) begin
        n_valid++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    tests++;
    if (n_valid != 8 || last_c - first_c != 7 || first_c != 5) begin
      failed++;
      $display("FAIL back_to_back_run: got %0d valids at cycles %0d..%0d required 8 at 5..12",
               n_valid, first_c, last_c);
    end
  endtask

  task automatic test_hold();
    bund_t e, m, prev;
    int first_c;
    first_c = -1;
    for (int c = 0; c < 22; c++) begin
      prev = obs;
      if (c >= 4 && c < 7) clk_cycle(1'b1, 1'b1, $urandom(), $urandom(), 1'b1);
      else if (c == 0)     clk_cycle(1'b0, 1'b1, 32'd100, 32'd1, 1'b0);
      else if (c < 10)     clk_cycle(1'b0, 1'b1, rnd_word(), rnd_word(), 1'($urandom()));
      else                 clk_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      model_expect(e, m);
      tests++;
      if ((obs & m) !== (e & m)) begin
        failed++;
        $display("FAIL hold c=%0d: got %h required %h", c, obs, e);
      end
      if (c >= 4 && c < 7) begin
        tests++;
        if (obs !== prev) begin
          failed++;
          $display("FAIL hold_frozen c=%0d: got %h required %h", c, obs, prev);
        end
      end
      if (out_valid === 1'b1 && first_c < 0) first_c = c;
    end
    // First op issued on cycle 0 emerges after 6 + 3 edges.
    tests++;
    if (first_c != 8) begin
      failed++;
      $display("FAIL hold_latency: got first valid at cycle %0d required 8", first_c);
    end
  endtask

  task automatic test_reset_inflight();
    bund_t e, m;
    for (int c = 0; c < 22; c++) begin
      rst = (c == 4);
      if (c < 5)       clk_cycle(1'b0, 1'b1, rnd_word(), rnd_word(), 1'($urandom()));
      else if (c == 13) clk_cycle(1'b0, 1'b1, 32'd5, 32'd5, 1'b0);
      else             clk_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      model_expect(e, m);
      tests++;
      if ((obs & m) !== (e & m)) begin
        failed++;
        $display("FAIL reset_inflight c=%0d: got %h required %h", c, obs, e);
      end
      if (c == 18) begin
        tests++;
        if (obs !== ref_result(32'd5, 32'd5, 1'b0)) begin
          failed++;
          $display("FAIL reset_inflight_5m5: got %h required %h", obs, ref_result(32'd5, 32'd5, 1'b0));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    bund_t e, m;
    for (int c = 0; c < 400; c++) begin
      if (c < 380)
        clk_cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7),
                  rnd_word(), rnd_word(), 1'($urandom()));
      else
        clk_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      model_expect(e, m);
      tests++;
      if ((obs & m) !== (e & m)) begin
        failed++;
        $display("FAIL random c=%0d: got %h required %h", c, obs, e);
      end
    end
    tests++;
    if (pend.size() != 0) begin
      failed++;
      $display("FAIL random_drain: got %0d ops never emitted required 0", pend.size());
    end
  endtask

  initial begin
    tests = 0; failed = 0; adv_cnt = 0;
    last_rst = 1'b0; last_hold = 1'b0; exp_last = '0; msk_last = '0;
    rst = 1'b1; hold = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
